// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM states and port ids.
package mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the arbiter and its loader, CPU ports and memory array.
interface memory_arbiter_if #(
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_pkg::DEF_DATA_W
);
    logic              ld_write;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              cpu_run;

    modport slave (
        input  ld_write, ld_addr, ld_data, ld_done,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output cpu_run
    );

    modport master (
        output ld_write, ld_addr, ld_data, ld_done,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  cpu_run
    );

endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is the fetch port, req[1]/gnt[1] the data port.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == PORT_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) last_d = PORT_IF;
        if (gnt[1]) last_d = PORT_DM;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_q <= PORT_IF;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Sequences the shared program/data memory: loader ownership at boot, then
// round-robin between CPU fetch and data ports once the core is released.
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BOOT_HOLD = 2
) (
    input  logic             clock,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cpu_run_q, cpu_run_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // Stage 0 is the cycle the address sits on the memory, stage 1 the data cycle.
    logic [1:0]        rd_vld_q, rd_vld_d;
    logic [1:0]        rd_own_q, rd_own_d;

    logic [1:0] arb_req;
    logic [1:0] gnt;

    assign arb_req = (state_q == RUN && !bus.ld_write) ? {bus.dm_req, bus.if_req} : 2'b00;

    rr_arbiter2 u_rr (
        .clock (clock),
        .reset (reset),
        .req   (arb_req),
        .gnt   (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_vld_d    = {rd_vld_q[0], 1'b0};
        rd_own_d    = {rd_own_q[0], 1'b0};

        if (bus.ld_write) begin
            // A loader write always wins and drops the core back to boot from any state.
            state_d     = BOOT;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_data;
        end else begin
            unique case (state_q)
                BOOT: begin
                    if (bus.ld_done) begin
                        state_d = HOLD;
                        cnt_d   = 4'(BOOT_HOLD);
                    end
                end
                HOLD: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RUN;
                end
                RUN: begin
                    if (gnt[0]) begin
                        mem_addr_d  = bus.if_addr;
                        rd_vld_d[0] = 1'b1;
                        rd_own_d[0] = PORT_IF;
                    end else if (gnt[1]) begin
                        mem_addr_d  = bus.dm_addr;
                        mem_we_d    = bus.dm_we;
                        rd_vld_d[0] = !bus.dm_we;
                        rd_own_d[0] = PORT_DM;
                        if (bus.dm_we) mem_wdata_d = bus.dm_wdata;
                    end
                end
                default: state_d = BOOT;
            endcase
        end

        cpu_run_d = (state_d == RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            cnt_q       <= '0;
            cpu_run_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_vld_q    <= '0;
            rd_own_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_run_q   <= cpu_run_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
        end
    end

    assign bus.if_gnt    = gnt[0];
    assign bus.dm_gnt    = gnt[1];
    assign bus.if_rvalid = rd_vld_q[1] && (rd_own_q[1] == PORT_IF);
    assign bus.dm_rvalid = rd_vld_q[1] && (rd_own_q[1] == PORT_DM);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_run   = cpu_run_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: issued reads queue their expected data,
// a monitor pops and compares whenever a read-valid appears.
module tb_memory_arbiter;
    import mem_pkg::*;

    localparam int BOOT_HOLD = 2;

    logic clock;
    logic reset;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .ADDR_W    (DEF_ADDR_W),
        .DATA_W    (DEF_DATA_W),
        .BOOT_HOLD (BOOT_HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory array: data appears the cycle after the address.
    logic [15:0] tb_mem [32];
    always @(posedge clock) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr];
    end

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     sb [$];
    logic [15:0] model_mem [32];
    logic        last_port;
    logic        model_run;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpu_run"}, bus.cpu_run, 0);
        chk({tag, "_gnt"}, {bus.if_gnt, bus.dm_gnt}, 0);
        chk({tag, "_rvalid"}, {bus.if_rvalid, bus.dm_rvalid}, 0);
        chk({tag, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic drive_idle();
        bus.ld_write = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic run_cycle(input logic ir, input logic [4:0] ia,
                             input logic dr, input logic dw, input logic [4:0] da, input logic [15:0] dd,
                             input logic lw, input logic [4:0] la, input logic [15:0] ld);
        logic g_if, g_dm, exp_we;
        logic [4:0]  exp_addr;
        logic [15:0] exp_wdata;
        bus.if_req = ir; bus.if_addr = ia;
        bus.dm_req = dr; bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
        bus.ld_write = lw; bus.ld_addr = la; bus.ld_data = ld; bus.ld_done = 0;
        #1;
        g_if = 0; g_dm = 0;
        if (model_run && !lw) begin
            if (ir && dr) begin
                g_if = (last_port == PORT_DM);
                g_dm = (last_port == PORT_IF);
            end else begin
                g_if = ir;
                g_dm = dr;
            end
        end
        chk("if_gnt", bus.if_gnt, g_if);
        chk("dm_gnt", bus.dm_gnt, g_dm);
        exp_we = 0; exp_addr = '0; exp_wdata = '0;
        if (g_if) begin
            last_port = PORT_IF;
            sb.push_back('{port: PORT_IF, data: model_mem[ia]});
            exp_addr = ia;
        end
        if (g_dm) begin
            last_port = PORT_DM;
            exp_addr = da;
            if (dw) begin
                model_mem[da] = dd;
                exp_we = 1; exp_wdata = dd;
            end else begin
                sb.push_back('{port: PORT_DM, data: model_mem[da]});
            end
        end
        if (lw) begin
            model_mem[la] = ld;
            model_run = 0;
            exp_we = 1; exp_addr = la; exp_wdata = ld;
        end
        @(posedge clock); #1;
        chk("mem_we", bus.mem_we, exp_we);
        if (g_if || g_dm || lw) chk("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("cpu_run", bus.cpu_run, model_run);
        @(negedge clock);
    endtask

    task automatic load_word(input logic [4:0] a, input logic [15:0] d);
        run_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  16'($urandom), 1'b1, a, d);
    endtask

    // Raise ld_done and count cycles until cpu_run; both ports request throughout.
    task automatic release_cpu();
        int cycles;
        drive_idle();
        bus.ld_done = 1; bus.if_req = 1; bus.dm_req = 1;
        cycles = 0;
        do begin
            @(posedge clock); #1;
            bus.ld_done = 0;
            cycles++;
            if (!bus.cpu_run) chk("hold_no_gnt", {bus.if_gnt, bus.dm_gnt}, 0);
        end while (!bus.cpu_run && cycles < 20);
        bus.if_req = 0; bus.dm_req = 0;
        chk("cpu_run_latency", cycles, BOOT_HOLD + 1);
        model_run = 1;
        @(negedge clock);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      16'($urandom), 1'b0, 5'd0, 16'd0);
    endtask

    task automatic apply_reset_midcycle(input string tag);
        drive_idle();
        #2 reset = 1;
        #1 check_all_zero(tag);
        sb.delete();
        last_port = PORT_IF;
        model_run = 0;
        @(negedge clock); @(negedge clock);
        reset = 0;
    endtask

    initial begin : monitor
        rd_exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.if_rvalid || bus.dm_rvalid) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", {bus.dm_rvalid, bus.if_rvalid}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rvalid_port", {bus.dm_rvalid, bus.if_rvalid}, e.port ? 2'b10 : 2'b01);
                        chk("rdata", e.port ? bus.dm_rdata : bus.if_rdata, e.data);
                    end
                end else begin
                    chk("rdata_idle", {bus.if_rdata, bus.dm_rdata}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        mismatched++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : stimulus
        drive_idle();
        last_port = PORT_IF;
        model_run = 0;
        reset = 1;
        @(negedge clock);
        check_all_zero("reset");
        @(negedge clock);
        reset = 0;

        // Boot: fill the whole array, ending with 0xA5A5 at address 3.
        for (int a = 0; a < 32; a++)
            if (a != 3) load_word(5'(a), 16'($urandom));
        load_word(5'd3, 16'hA5A5);
        release_cpu();

        // Contention straight after boot: expect DM, IF, DM, IF.
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 5'd3, 1'b1, 1'b0, 5'd7, 16'd0, 1'b0, 5'd0, 16'd0);
        drive_idle();
        run_cycle(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);

        // Single fetch, then a data write at the top address and its readback.
        run_cycle(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        run_cycle(1'b0, 5'd0, 1'b1, 1'b1, 5'd31, 16'h1234, 1'b0, 5'd0, 16'd0);
        run_cycle(1'b0, 5'd0, 1'b1, 1'b0, 5'd31, 16'd0, 1'b0, 5'd0, 16'd0);

        random_traffic(200);

        // Reload while a fetch is in flight.
        run_cycle(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        run_cycle(1'b1, 5'd6, 1'b1, 1'b0, 5'd8, 16'd0, 1'b1, 5'd9, 16'hBEEF);
        run_cycle(1'b1, 5'd6, 1'b1, 1'b0, 5'd8, 16'd0, 1'b0, 5'd0, 16'd0);
        load_word(5'd10, 16'hC0DE);
        release_cpu();
        random_traffic(60);

        // Reset with a read outstanding.
        run_cycle(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0);
        apply_reset_midcycle("rst_read");
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 16'd0, 1'b0, 5'd0, 16'd0);
        load_word(5'd4, 16'h0F0F);
        release_cpu();
        random_traffic(40);

        // Reset while in HOLD.
        drive_idle();
        load_word(5'd12, 16'h5555);
        bus.ld_done = 1;
        @(posedge clock); #1;
        bus.ld_done = 0;
        @(posedge clock);
        apply_reset_midcycle("rst_hold");
        for (int i = 0; i < 6; i++)
            run_cycle(1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 16'h7777, 1'b0, 5'd0, 16'd0);
        release_cpu();
        random_traffic(60);

        drive_idle();
        repeat (4) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
